// File: rtl/joltage_stream_sequencer.sv
// Byte-stream front end for joltage_calc_unit: parses digit lines, delays each
// digit by one so the last digit of a bank carries bank_end, and captures the total.
module joltage_stream_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [3:0]  joltage_out,
  output logic        joltage_out_valid,
  output logic        bank_end_out,
  output logic        end_of_puzzle_out,
  input  logic [15:0] total_in,
  input  logic        total_in_valid,
  output logic        calc_clear,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ack,
  output logic [15:0] bank_count,
  output logic        format_error
);

  // state   | meaning
  // S_IDLE  | no digit held
  // S_HOLD  | one digit held in held_q
  // S_FLUSH | held digit already emitted as bank end, end strobe goes out next
  // S_FINAL | end strobe visible, total captured from calc unit
  // S_DONE  | result held for host
  // S_CLEAR | calc_clear pulse
  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_FLUSH, S_FINAL, S_DONE, S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  held_q, held_d;
  logic        accept;
  logic        is_digit, is_nl, is_cr, is_eot, is_illegal;
  logic        emit, emit_be, emit_eop;
  logic [3:0]  emit_val;
  logic        count_inc, capture, fe_set, fe_clr;

  assign rx_ready   = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign accept     = rx_valid && rx_ready;
  assign is_digit   = (rx_byte >= 8'h31) && (rx_byte <= 8'h39);
  assign is_nl      = (rx_byte == 8'h0A);
  assign is_cr      = (rx_byte == 8'h0D);
  assign is_eot     = (rx_byte == 8'h04);
  assign is_illegal = !(is_digit || is_nl || is_cr || is_eot);

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    emit      = 1'b0;
    emit_val  = 4'd0;
    emit_be   = 1'b0;
    emit_eop  = 1'b0;
    count_inc = 1'b0;
    capture   = 1'b0;
    fe_set    = 1'b0;
    fe_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            held_d  = rx_byte[3:0];
            state_d = S_HOLD;
          end else if (is_eot) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            state_d  = S_FINAL;
          end else if (is_illegal) begin
            fe_set = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (accept) begin
          if (is_digit) begin
            emit     = 1'b1;
            emit_val = held_q;
            held_d   = rx_byte[3:0];
          end else if (is_nl || is_eot) begin
            emit      = 1'b1;
            emit_val  = held_q;
            emit_be   = 1'b1;
            count_inc = 1'b1;
            state_d   = is_eot ? S_FLUSH : S_IDLE;
          end else if (is_illegal) begin
            fe_set = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        emit     = 1'b1;
        emit_eop = 1'b1;
        state_d  = S_FINAL;
      end
      S_FINAL: begin
        capture = total_in_valid;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ack) begin
          fe_clr  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      held_q            <= 4'd0;
      joltage_out       <= 4'd0;
      joltage_out_valid <= 1'b0;
      bank_end_out      <= 1'b0;
      end_of_puzzle_out <= 1'b0;
      result            <= 16'd0;
      result_valid      <= 1'b0;
      bank_count        <= 16'd0;
      format_error      <= 1'b0;
      calc_clear        <= 1'b1;
    end else begin
      state_q           <= state_d;
      held_q            <= held_d;
      joltage_out       <= emit_val;
      joltage_out_valid <= emit;
      bank_end_out      <= emit_be;
      end_of_puzzle_out <= emit_eop;
      calc_clear        <= (state_d == S_CLEAR);
      if (capture)
        result <= total_in;
      if (state_q == S_FINAL)
        result_valid <= 1'b1;
      else if (state_q == S_CLEAR)
        result_valid <= 1'b0;
      // count saturates rather than wrapping
      if (state_q == S_CLEAR)
        bank_count <= 16'd0;
      else if (count_inc && (bank_count != 16'hFFFF))
        bank_count <= bank_count + 16'd1;
      if (fe_set)
        format_error <= 1'b1;
      else if (fe_clr)
        format_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_joltage_stream_sequencer.sv
// Bench for joltage_stream_sequencer: byte vector table plus hand sequences;
// emits are checked against a scoreboard queue filled when bytes are driven.
module tb_joltage_stream_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  joltage_out;
  logic        joltage_out_valid;
  logic        bank_end_out;
  logic        end_of_puzzle_out;
  logic [15:0] total_in;
  logic        total_in_valid;
  logic        calc_clear;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ack;
  logic [15:0] bank_count;
  logic        format_error;

  joltage_stream_sequencer dut (
    .clk(clk), .reset(reset),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .joltage_out(joltage_out), .joltage_out_valid(joltage_out_valid),
    .bank_end_out(bank_end_out), .end_of_puzzle_out(end_of_puzzle_out),
    .total_in(total_in), .total_in_valid(total_in_valid),
    .calc_clear(calc_clear), .result(result), .result_valid(result_valid),
    .result_ack(result_ack), .bank_count(bank_count), .format_error(format_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] b;
    int         nexp;
    logic [5:0] e0;
    logic [5:0] e1;
    logic       fe;
  } vec_t;

  vec_t       vt[26];
  logic [5:0] sb[$];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [5:0] ex(input int j, input int be, input int eop);
    logic [3:0] jj;
    jj = j[3:0];
    return {jj, be[0], eop[0]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard consumer: every emit pulse must match the oldest expected emit
  always @(negedge clk) begin
    if (joltage_out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_emit", {joltage_out, bank_end_out, end_of_puzzle_out}, -1);
      end else begin
        logic [5:0] e;
        e = sb.pop_front();
        chk("emit", {26'd0, joltage_out, bank_end_out, end_of_puzzle_out}, {26'd0, e});
      end
    end else if (end_of_puzzle_out) begin
      chk("eop_without_valid", 1, 0);
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vt[i].nexp > 0) sb.push_back(vt[i].e0);
      if (vt[i].nexp > 1) sb.push_back(vt[i].e1);
      send(vt[i].b);
      chk($sformatf("fe_after_vec%0d", i), int'(format_error), int'(vt[i].fe));
    end
  endtask

  // called in the cycle after EOT was accepted; lat = extra edges until result_valid
  task automatic finish_puzzle(input int lat, input int exp_res, input int exp_cnt, input int exp_fe);
    repeat (lat - 1) begin
      @(posedge clk);
      #1;
    end
    chk("result_valid_early", int'(result_valid), 0);
    @(posedge clk);
    #1;
    chk("result_valid", int'(result_valid), 1);
    chk("result", int'(result), exp_res);
    chk("bank_count", int'(bank_count), exp_cnt);
    chk("format_error_done", int'(format_error), exp_fe);
    chk("rx_ready_done", int'(rx_ready), 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    chk("calc_clear_pulse", int'(calc_clear), 1);
    chk("result_valid_in_clear", int'(result_valid), 1);
    chk("rx_ready_in_clear", int'(rx_ready), 0);
    @(posedge clk);
    #1;
    chk("calc_clear_after", int'(calc_clear), 0);
    chk("result_valid_cleared", int'(result_valid), 0);
    chk("bank_count_cleared", int'(bank_count), 0);
    chk("format_error_cleared", int'(format_error), 0);
    chk("rx_ready_after_clear", int'(rx_ready), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_calc_clear", int'(calc_clear), 1);
    chk("rst_rx_ready", int'(rx_ready), 1);
    chk("rst_valid", int'(joltage_out_valid), 0);
    chk("rst_joltage", int'(joltage_out), 0);
    chk("rst_bank_end", int'(bank_end_out), 0);
    chk("rst_eop", int'(end_of_puzzle_out), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_bank_count", int'(bank_count), 0);
    chk("rst_format_error", int'(format_error), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // "987\n" EOT
    vt[0]  = '{8'h39, 0, 6'd0, 6'd0, 1'b0};
    vt[1]  = '{8'h38, 1, ex(9,0,0), 6'd0, 1'b0};
    vt[2]  = '{8'h37, 1, ex(8,0,0), 6'd0, 1'b0};
    vt[3]  = '{8'h0A, 1, ex(7,1,0), 6'd0, 1'b0};
    vt[4]  = '{8'h04, 1, ex(0,0,1), 6'd0, 1'b0};
    // "12\n\r\n34" EOT, no trailing newline
    vt[5]  = '{8'h31, 0, 6'd0, 6'd0, 1'b0};
    vt[6]  = '{8'h32, 1, ex(1,0,0), 6'd0, 1'b0};
    vt[7]  = '{8'h0A, 1, ex(2,1,0), 6'd0, 1'b0};
    vt[8]  = '{8'h0D, 0, 6'd0, 6'd0, 1'b0};
    vt[9]  = '{8'h0A, 0, 6'd0, 6'd0, 1'b0};
    vt[10] = '{8'h33, 0, 6'd0, 6'd0, 1'b0};
    vt[11] = '{8'h34, 1, ex(3,0,0), 6'd0, 1'b0};
    vt[12] = '{8'h04, 2, ex(4,1,0), ex(0,0,1), 1'b0};
    // "5a0\n" EOT
    vt[13] = '{8'h35, 0, 6'd0, 6'd0, 1'b0};
    vt[14] = '{8'h61, 0, 6'd0, 6'd0, 1'b1};
    vt[15] = '{8'h30, 0, 6'd0, 6'd0, 1'b1};
    vt[16] = '{8'h0A, 1, ex(5,1,0), 6'd0, 1'b1};
    vt[17] = '{8'h04, 1, ex(0,0,1), 6'd0, 1'b1};
    // EOT only
    vt[18] = '{8'h04, 1, ex(0,0,1), 6'd0, 1'b0};
    // "6" EOT, then held '2' picked up after clear, "\n" EOT
    vt[19] = '{8'h36, 0, 6'd0, 6'd0, 1'b0};
    vt[20] = '{8'h04, 2, ex(6,1,0), ex(0,0,1), 1'b0};
    vt[21] = '{8'h0A, 1, ex(2,1,0), 6'd0, 1'b0};
    vt[22] = '{8'h04, 1, ex(0,0,1), 6'd0, 1'b0};
    // '7' then reset; afterwards "\n" EOT
    vt[23] = '{8'h37, 0, 6'd0, 6'd0, 1'b0};
    vt[24] = '{8'h0A, 0, 6'd0, 6'd0, 1'b0};
    vt[25] = '{8'h04, 1, ex(0,0,1), 6'd0, 1'b0};

    reset = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; result_ack = 1'b0;
    total_in = 16'd0; total_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    chk("calc_clear_first_cycle", int'(calc_clear), 1);
    @(posedge clk);
    #1;
    chk("calc_clear_released", int'(calc_clear), 0);

    total_in = 16'd98;
    run(0, 4);
    finish_puzzle(1, 98, 1, 0);
    do_ack();

    total_in = 16'd1234;
    run(5, 12);
    chk("flush_rx_ready", int'(rx_ready), 0);
    chk("flush_valid", int'(joltage_out_valid), 1);
    chk("flush_bank_end", int'(bank_end_out), 1);
    chk("flush_joltage", int'(joltage_out), 4);
    finish_puzzle(2, 1234, 2, 0);
    do_ack();

    total_in = 16'd55;
    run(13, 17);
    finish_puzzle(1, 55, 1, 1);
    do_ack();

    total_in = 16'd0;
    run(18, 18);
    finish_puzzle(1, 0, 0, 0);
    do_ack();

    total_in = 16'd42;
    run(19, 20);
    rx_byte  = 8'h32;
    rx_valid = 1'b1;
    finish_puzzle(2, 42, 1, 0);
    do_ack();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    total_in = 16'd21;
    run(21, 22);
    finish_puzzle(1, 21, 1, 0);
    do_ack();

    total_in = 16'd42;
    run(23, 23);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("calc_clear_in_reset", int'(calc_clear), 1);
    reset = 1'b1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    chk("calc_clear_post_reset", int'(calc_clear), 0);
    total_in = 16'd7;
    run(24, 25);
    finish_puzzle(1, 7, 0, 0);
    do_ack();

    repeat (3) @(negedge clk);
    chk("sb_final_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/joltage_stream_sequencer.md
# joltage_stream_sequencer

Byte-stream front end and sequencer for `joltage_calc_unit`. Accepts the puzzle input as ASCII bytes, which are one bank per line. It converts each digit to a joltage value, delays it by one digit so that the last digit of a bank carries `bank_end`, and issues the end-of-puzzle strobe. It captures the final sum, holds it for the host, and clears the calc unit between puzzles.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `rx_byte` in 8: ASCII input byte.
- `rx_valid` in 1: `rx_byte` is valid.
- `rx_ready` out 1: the sequencer accepts `rx_byte` this cycle. Transfer happens when `rx_valid & rx_ready`.
- `joltage_out` out 4: digit value, 1..9, to the calc unit. It is 0 on the end strobe.
- `joltage_out_valid` out 1: one-cycle strobe qualifying `joltage_out`, `bank_end_out` and `end_of_puzzle_out`.
- `bank_end_out` out 1: the current value is the last digit of its bank.
- `end_of_puzzle_out` out 1: end of the puzzle. It is only high together with `joltage_out_valid`.
- `total_in` in 16: `total_joltage_out` from the calc unit.
- `total_in_valid` in 1: `total_joltage_out_valid` from the calc unit.
- `calc_clear` out 1: active-high reset to the calc unit.
- `result` out 16: captured puzzle total.
- `result_valid` out 1: `result` holds a captured total.
- `result_ack` in 1: the host consumed `result`.
- `bank_count` out 16: number of banks issued in the current puzzle.
- `format_error` out 1: sticky flag. Set when an illegal byte is received; cleared on reset and on `result_ack`.

## Operation
- Byte classes:
  - digit `'1'..'9'` (0x31..0x39);
  - newline 0x0A;
  - ignored 0x0D;
  - end marker 0x04 (EOT);
  - everything else is illegal, including `'0'`. An illegal byte is dropped, sets `format_error`, and changes no other state.
- States:
  - **IDLE**: no digit held.
  - **HOLD**: one digit held in `held_q`.
  - **FLUSH**: emit the held digit as bank end before finishing.
  - **FINAL**: emit the end strobe.
  - **DONE**: result held.
  - **CLEAR**: pulse `calc_clear`.
- Transitions on an accepted byte:
  - IDLE + digit → HOLD. Store the digit; no emit.
  - HOLD + digit → HOLD. Emit the old `held_q` with `bank_end_out=0`; store the new digit.
  - HOLD + newline → IDLE. Emit `held_q` with `bank_end_out=1`; `bank_count` += 1.
  - IDLE + newline → IDLE. Empty line, ignored; no emit, no count.
  - IDLE + EOT → FINAL.
  - HOLD + EOT → FLUSH.
  - Ignored and illegal bytes leave the state unchanged.
- FLUSH, one cycle: emit `held_q` with `bank_end_out=1`, `bank_count` += 1, then go to FINAL. This handles a missing trailing newline.
- FINAL, one cycle:
  - Emit `joltage_out_valid=1`, `end_of_puzzle_out=1`, `joltage_out=0`, `bank_end_out=0`.
  - In the same cycle, when `total_in_valid=1`, register `total_in` into `result`.
  - Go to DONE.
- DONE: `result_valid=1` and `rx_ready=0`. On `result_ack`: clear `format_error`, go to CLEAR.
- CLEAR, one cycle: `calc_clear=1`, `bank_count` ← 0, `result_valid` ← 0, then go to IDLE.
- `rx_ready` = 1 in IDLE and HOLD only.
- At most one emit per cycle. At most one accepted byte per cycle.
- `bank_count` saturates at 0xFFFF.
- `result_ack` is ignored outside DONE.
- A puzzle with no banks (EOT only) is legal. FINAL emits the end strobe and `result` captures whatever the calc unit reports, 0 after a clear.

## Timing
- All outputs are registered except `rx_ready`, which is decoded from the state register.
- Reset values, applied when `reset=0` at a clock edge:
  - state IDLE, `rx_ready=1`;
  - `joltage_out=0`, `joltage_out_valid=0`, `bank_end_out=0`, `end_of_puzzle_out=0`;
  - `result=0`, `result_valid=0`;
  - `bank_count=0`, `format_error=0`;
  - `calc_clear=1`. It is held high throughout reset and for the first cycle after reset releases.
- Emit latency: the byte accepted at edge N produces the `joltage_out_valid` pulse in cycle N+1.
- EOT from HOLD, accepted at edge N:
  - FLUSH emit in cycle N+1;
  - end strobe in cycle N+2;
  - `result_valid` high from cycle N+3.
- EOT from IDLE: end strobe in cycle N+1; `result_valid` from cycle N+2.
- `result_ack` seen at edge M:
  - `calc_clear` high in cycle M+1;
  - `result_valid` low and `rx_ready` high from cycle M+2.
- Reset mid-stream discards the held digit, any pending emit, `result` and counters. No partial emit occurs after reset.

## Test plan
- Input `"987\n"` then EOT → three emits: (9,0), (8,0), (7,1). Then the end strobe with `joltage_out=0`. With `total_in=16'd98` asserted in the end cycle, `result=98`, `result_valid=1`, `bank_count=1`.
- Input `"12\n\r\n34"` then EOT with no final newline:
  - emits (1,0), (2,1), (3,0);
  - FLUSH emit (4,1) with `rx_ready=0`;
  - end strobe;
  - `bank_count=2`; the empty line is not counted.
- Input `"5a0\n"` → `format_error=1`. Emits are (5,1) only; the 'a' and '0' are dropped.
- Apply `result_ack` in DONE → `calc_clear` pulses for exactly one cycle. Then `result_valid=0`, `bank_count=0`, `format_error=0`, `rx_ready=1`.
- Hold `rx_valid=1` continuously with a digit byte during FLUSH, FINAL and DONE → no byte is consumed until `rx_ready` returns high, and the next accepted digit starts a new puzzle.
- Pull `reset` low while in HOLD with digit 7 → no emit of 7. After release, `calc_clear=1` for one cycle and all outputs are at their reset values.
